// File: rtl/lsu_if.sv
// Load/store unit handshake bundle: execute-stage request, memory bus, writeback and fault report.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        done;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc;
  logic [1:0]  exc_cause;
  logic [31:0] exc_addr;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  done, wb_we, wb_rd, wb_data, exc, exc_cause, exc_addr
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output done, wb_we, wb_rd, wb_data, exc, exc_cause, exc_addr
  );
endinterface

// File: rtl/lsu.sv
// Single-outstanding load/store unit (IDLE/REQ/WAIT) with bus timeout.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning them.
module lsu #(
  parameter int TIMEOUT_CYC = 255
) (
  input logic clk,
  input logic rst_n,
  lsu_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic        we_q, sext_q;
  logic [1:0]  size_q, off_q;
  logic [4:0]  rd_q;
  logic [31:0] addr_q;

  // size: 0 byte, 1 half, 2 word; unknown funct3 falls back to word
  logic [1:0]  size_d, off_d;
  logic [3:0]  strb_d;
  logic [31:0] wdata_d;
  logic        sext_d;

  always_comb begin
    sext_d = !bus.req_funct3[2];
    if (bus.req_we)
      size_d = (bus.req_funct3 == 3'b000) ? 2'd0 : (bus.req_funct3 == 3'b001) ? 2'd1 : 2'd2;
    else
      size_d = (bus.req_funct3[1:0] == 2'b00) ? 2'd0 : (bus.req_funct3[1:0] == 2'b01) ? 2'd1 : 2'd2;
    case (size_d)
      2'd0: begin
        off_d   = bus.req_addr[1:0];
        strb_d  = 4'b0001 << bus.req_addr[1:0];
        wdata_d = {4{bus.req_wdata[7:0]}};
      end
      2'd1: begin
        off_d   = {bus.req_addr[1], 1'b0};
        strb_d  = 4'b0011 << {bus.req_addr[1], 1'b0};
        wdata_d = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        off_d   = 2'b00;
        strb_d  = 4'b1111;
        wdata_d = bus.req_wdata;
      end
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_d;
  assign mis_d = ((size_d == 2'd1) && bus.req_addr[0]) || ((size_d == 2'd2) && (|bus.req_addr[1:0]));
`endif

  logic [31:0] rsh, ld_data;
  assign rsh = bus.mem_rdata >> {off_q, 3'b000};
  always_comb begin
    case (size_q)
      2'd0:    ld_data = {{24{sext_q & rsh[7]}}, rsh[7:0]};
      2'd1:    ld_data = {{16{sext_q & rsh[15]}}, rsh[15:0]};
      default: ld_data = bus.mem_rdata;
    endcase
  end

  assign bus.req_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      we_q          <= 1'b0;
      sext_q        <= 1'b0;
      size_q        <= '0;
      off_q         <= '0;
      rd_q          <= '0;
      addr_q        <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_wstrb <= '0;
      bus.done      <= 1'b0;
      bus.wb_we     <= 1'b0;
      bus.wb_rd     <= '0;
      bus.wb_data   <= '0;
      bus.exc       <= 1'b0;
      bus.exc_cause <= '0;
      bus.exc_addr  <= '0;
    end else begin
      bus.done  <= 1'b0;
      bus.wb_we <= 1'b0;
      bus.exc   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
`ifdef LSU_MISALIGN_TRAP_EN
            if (mis_d) begin
              bus.exc       <= 1'b1;
              bus.exc_cause <= {1'b0, bus.req_we};
              bus.exc_addr  <= bus.req_addr;
            end else
`endif
            begin
              state         <= REQ;
              cnt           <= '0;
              we_q          <= bus.req_we;
              sext_q        <= sext_d;
              size_q        <= size_d;
              off_q         <= off_d;
              rd_q          <= bus.req_rd;
              addr_q        <= bus.req_addr;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= bus.req_we;
              bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
              bus.mem_wdata <= wdata_d;
              bus.mem_wstrb <= bus.req_we ? strb_d : 4'b0000;
            end
          end
        end
        REQ, WAIT: begin
          // a response on the deadline cycle still wins over the abort
          if (state == REQ && bus.mem_gnt && !bus.mem_rvalid) begin
            bus.mem_req <= 1'b0;
            cnt         <= '0;
            state       <= WAIT;
          end else if ((state == REQ && bus.mem_gnt) || (state == WAIT && bus.mem_rvalid)) begin
            bus.mem_req <= 1'b0;
            bus.done    <= 1'b1;
            bus.wb_we   <= !we_q;
            bus.wb_rd   <= rd_q;
            bus.wb_data <= ld_data;
            state       <= IDLE;
          end else if (cnt == CNT_LAST) begin
            bus.mem_req   <= 1'b0;
            bus.exc       <= 1'b1;
            bus.exc_cause <= 2'd2;
            bus.exc_addr  <= addr_q;
            state         <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu.sv
// Randomized bench for lsu against a transaction-level model of the access rules.
module tb_lsu;
  localparam int TO = 8;

  logic clk, rst_n;
  int nvec = 0, nerr = 0;

  lsu_if b0();
  lsu_if b1();

  assign b1.req_valid  = b0.req_valid;
  assign b1.req_we     = b0.req_we;
  assign b1.req_funct3 = b0.req_funct3;
  assign b1.req_addr   = b0.req_addr;
  assign b1.req_wdata  = b0.req_wdata;
  assign b1.req_rd     = b0.req_rd;
  assign b1.mem_gnt    = b0.mem_gnt;
  assign b1.mem_rvalid = b0.mem_rvalid;
  assign b1.mem_rdata  = b0.mem_rdata;

  lsu #(.TIMEOUT_CYC(TO)) u_dut (.clk(clk), .rst_n(rst_n), .bus(b0));
  lsu #(.TIMEOUT_CYC(4))  u_to4 (.clk(clk), .rst_n(rst_n), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running exp finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h exp %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sz(input logic we, input logic [2:0] f3);
    if (we) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
  endfunction

  task automatic chk_reset(input string pfx);
    chk({pfx, "_req_ready"}, b0.req_ready, 1);
    chk({pfx, "_mem_req"},   b0.mem_req, 0);
    chk({pfx, "_mem_we"},    b0.mem_we, 0);
    chk({pfx, "_done"},      b0.done, 0);
    chk({pfx, "_wb_we"},     b0.wb_we, 0);
    chk({pfx, "_exc"},       b0.exc, 0);
    chk({pfx, "_mem_addr"},  b0.mem_addr, 0);
    chk({pfx, "_mem_wdata"}, b0.mem_wdata, 0);
    chk({pfx, "_mem_wstrb"}, b0.mem_wstrb, 0);
    chk({pfx, "_wb_rd"},     b0.wb_rd, 0);
    chk({pfx, "_wb_data"},   b0.wb_data, 0);
    chk({pfx, "_exc_cause"}, b0.exc_cause, 0);
    chk({pfx, "_exc_addr"},  b0.exc_addr, 0);
  endtask

  task automatic chk_abort(input logic [31:0] addr);
    chk("to_exc", b0.exc, 1);
    chk("to_cause", b0.exc_cause, 2);
    chk("to_exc_addr", b0.exc_addr, addr);
    chk("to_done", b0.done, 0);
    chk("to_mem_req", b0.mem_req, 0);
    chk("to_ready", b0.req_ready, 1);
    step();
    chk("to_exc_once", b0.exc, 0);
    chk("to_ready_next", b0.req_ready, 1);
  endtask

  // d: grant arrives in the d-th cycle of mem_req; rv: response rv cycles after grant (0 = with grant)
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd, input int d, input int rv,
                         input logic [31:0] rdata);
    int s, off;
    logic [31:0] maddr, wexp, ld;
    logic [3:0] strb;
    bit trap;
    s     = sz(we, f3);
    off   = int'(addr % 4) - int'(addr % 4) % s;
    maddr = addr - addr % 4;
    strb  = 4'(((1 << s) - 1) << off);
    wexp  = (s == 1) ? (wd & 32'hff) * 32'h0101_0101 :
            (s == 2) ? (wd & 32'hffff) * 32'h0001_0001 : wd;
    ld    = rdata >> (8 * off);
    if (s == 1) begin
      ld = ld & 32'hff;
      if (f3 == 3'd0 && ld >= 128) ld = ld | 32'hffff_ff00;
    end else if (s == 2) begin
      ld = ld & 32'hffff;
      if (f3 == 3'd1 && ld >= 32768) ld = ld | 32'hffff_0000;
    end
    trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = (addr % s) != 0;
`endif
    chk("idle_ready", b0.req_ready, 1);
    b0.req_valid = 1'b1; b0.req_we = we; b0.req_funct3 = f3;
    b0.req_addr = addr; b0.req_wdata = wd; b0.req_rd = rd;
    step();
    b0.req_valid = 1'b0; b0.req_addr = $urandom; b0.req_wdata = $urandom;
    b0.req_rd = 5'($urandom); b0.req_we = 1'($urandom);
    if (trap) begin
      chk("mis_exc", b0.exc, 1);
      chk("mis_cause", b0.exc_cause, {31'd0, we});
      chk("mis_exc_addr", b0.exc_addr, addr);
      chk("mis_mem_req", b0.mem_req, 0);
      chk("mis_ready", b0.req_ready, 1);
      step();
      chk("mis_exc_once", b0.exc, 0);
      chk("mis_mem_req2", b0.mem_req, 0);
      return;
    end
    for (int k = 1; k <= d && k <= TO; k++) begin
      chk("mem_req", b0.mem_req, 1);
      chk("mem_addr", b0.mem_addr, maddr);
      chk("mem_we", b0.mem_we, we);
      if (we) begin
        chk("mem_wdata", b0.mem_wdata, wexp);
        chk("mem_wstrb", b0.mem_wstrb, strb);
      end
      chk("busy_ready", b0.req_ready, 0);
      b0.mem_gnt    = (k == d);
      b0.mem_rvalid = (k == d && rv == 0);
      b0.mem_rdata  = (k == d && rv == 0) ? rdata : $urandom;
      step();
      b0.mem_gnt = 1'b0; b0.mem_rvalid = 1'b0;
    end
    if (d > TO) begin
      chk_abort(addr);
      return;
    end
    chk("gnt_drop", b0.mem_req, 0);
    for (int j = 1; rv > 0 && j <= rv && j <= TO; j++) begin
      chk("wait_done", b0.done, 0);
      chk("wait_ready", b0.req_ready, 0);
      b0.mem_rvalid = (j == rv);
      b0.mem_rdata  = (j == rv) ? rdata : $urandom;
      step();
      b0.mem_rvalid = 1'b0;
    end
    if (rv > TO) begin
      chk_abort(addr);
      return;
    end
    chk("done", b0.done, 1);
    chk("done_exc", b0.exc, 0);
    chk("wb_we", b0.wb_we, !we);
    chk("wb_rd", b0.wb_rd, rd);
    if (!we) chk("wb_data", b0.wb_data, ld);
    step();
    chk("done_pulse", b0.done, 0);
    chk("wb_we_pulse", b0.wb_we, 0);
  endtask

  int exc4, done4, exc4_at, exc8_at;
  logic [1:0] cause4;
  logic ready4_after;

  initial begin
    rst_n = 1'b0;
    b0.req_valid = 0; b0.req_we = 0; b0.req_funct3 = 0; b0.req_addr = 0;
    b0.req_wdata = 0; b0.req_rd = 0; b0.mem_gnt = 0; b0.mem_rvalid = 0; b0.mem_rdata = 0;
    #2;
    chk_reset("rst");
    step();
    rst_n = 1'b1;
    step();

    // LB sign-extended top byte, minimum latency
    run_txn(1'b0, 3'b000, 32'h103, 32'h0, 5'd7, 1, 1, 32'h80FF_FF00);
    // SH replicated into upper half
    run_txn(1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 5'd3, 1, 1, 32'h0);
    // grant withheld 5 cycles
    run_txn(1'b0, 3'b010, 32'h400, 32'h0, 5'd9, 6, 1, 32'hDEAD_BEEF);
    // misaligned word load
    run_txn(1'b0, 3'b010, 32'h6, 32'h0, 5'd1, 1, 0, 32'h1357_9BDF);
    run_txn(1'b0, 3'b101, 32'h3, 32'h0, 5'd2, 2, 0, 32'hFEDC_BA98);

    // timeout on a 4-cycle instance; the 8-cycle one aborts later
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    b0.req_valid = 1'b1; b0.req_we = 1'b0; b0.req_funct3 = 3'b010; b0.req_addr = 32'h40;
    step();
    b0.req_valid = 1'b0; b0.mem_gnt = 1'b1;
    step();
    b0.mem_gnt = 1'b0;
    exc4 = 0; done4 = 0; exc4_at = 0; exc8_at = 0; cause4 = 0; ready4_after = 0;
    for (int c = 2; c <= 13; c++) begin
      if (b1.exc) begin exc4++; exc4_at = c; cause4 = b1.exc_cause; end
      if (b1.done) done4++;
      if (c == 7) ready4_after = b1.req_ready;
      if (b0.exc && exc8_at == 0) exc8_at = c;
      step();
    end
    chk("to4_exc_count", exc4, 1);
    chk("to4_exc_cycle", exc4_at, 6);
    chk("to4_cause", cause4, 2);
    chk("to4_done", done4, 0);
    chk("to4_ready_next", ready4_after, 1);
    chk("to8_exc_cycle", exc8_at, 10);

    // reset while waiting for the response, then a late response
    b0.req_valid = 1'b1; b0.req_we = 1'b0; b0.req_funct3 = 3'b010; b0.req_addr = 32'h80;
    step();
    b0.req_valid = 1'b0; b0.mem_gnt = 1'b1;
    step();
    b0.mem_gnt = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    step();
    rst_n = 1'b1;
    b0.mem_rvalid = 1'b1; b0.mem_rdata = 32'hAAAA_5555;
    step();
    b0.mem_rvalid = 1'b0;
    chk("late_rvalid_done", b0.done, 0);
    chk("late_rvalid_wb", b0.wb_we, 0);
    chk("late_rvalid_mem_req", b0.mem_req, 0);
    run_txn(1'b0, 3'b100, 32'h81, 32'h0, 5'd5, 1, 2, 32'h0000_F000);

    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom), 3'($urandom), $urandom, $urandom, 5'($urandom),
              int'($urandom_range(1, 10)), int'($urandom_range(0, 10)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, SHALL give the maximum cycles to wait in REQ or WAIT before the access is aborted; legal range 1..255.
REQ-002 clk  input  1  SHALL be the sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 req_valid  input  1  SHALL mean the execute stage presents an access.
REQ-005 req_ready  output  1  SHALL mean the LSU accepts an access this cycle.
REQ-006 req_we  input  1; req_funct3  input  3; req_addr  input  32 (ALU sum); req_wdata  input  32; req_rd  input  5: SHALL be the access descriptor, sampled on handshake.
REQ-007 mem_req  output  1; mem_we  output  1; mem_addr  output  32; mem_wdata  output  32; mem_wstrb  output  4: SHALL form the bus request.
REQ-008 mem_gnt  input  1; mem_rvalid  input  1; mem_rdata  input  32: SHALL be the bus grant and the bus response.
REQ-009 done  output  1; wb_we  output  1; wb_rd  output  5; wb_data  output  32: SHALL carry the completion to writeback.
REQ-010 exc  output  1; exc_cause  output  2 (0 load-misalign, 1 store-misalign, 2 timeout); exc_addr  output  32: SHALL carry the fault report.

Function
REQ-011 The FSM SHALL have states IDLE, REQ and WAIT; req_ready SHALL be 1 only in IDLE.
REQ-012 On req_valid&req_ready the block SHALL latch the descriptor and enter REQ, asserting mem_req from the next cycle.
REQ-013 In REQ, mem_req and all mem_* outputs SHALL be held stable until mem_gnt; on mem_gnt the FSM SHALL go to WAIT, or on mem_gnt&mem_rvalid directly complete.
REQ-014 In WAIT, mem_rvalid SHALL complete the access; done SHALL pulse for exactly 1 cycle on the cycle after the completing edge, then the FSM returns to IDLE.
REQ-015 Minimum latency SHALL be: accept at N, mem_req at N+1, done at N+3 with gnt at N+1 and rvalid at N+2.
REQ-016 mem_addr SHALL be {addr[31:2],2'b00}; mem_rvalid outside REQ/WAIT SHALL be ignored.
REQ-017 Loads (funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU) SHALL select the byte or halfword by addr[1:0], then sign-extend or zero-extend it to wb_data; wb_we=1 and wb_rd=latched rd.
REQ-018 Stores (000 SB, 001 SH, 010 SW) SHALL replicate data (byte x4, half x2); mem_wstrb SHALL be 0001<<addr[1:0], 0011<<addr[1:0] or 1111; wb_we=0.
REQ-019 Any other funct3 SHALL be handled as LW/SW.
REQ-020 A timeout counter SHALL reset on entering REQ and on entering WAIT; reaching TIMEOUT_CYC SHALL abort the access: mem_req drops, exc pulses with cause 2, done stays 0, and the FSM returns to IDLE.
REQ-021 exc and done SHALL never be asserted in the same cycle.

Reset
REQ-022 rst_n low SHALL immediately force IDLE and clear req_ready->1, mem_req, mem_we, done, wb_we and exc to 0, and mem_addr, mem_wdata, mem_wstrb, wb_rd, wb_data, exc_cause, exc_addr and the counter to 0, including mid-access.
REQ-023 A mem_rvalid belonging to an access aborted by reset SHALL be ignored.

Configuration
REQ-024 With LSU_MISALIGN_TRAP_EN defined, a halfword access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL issue no bus request: exc pulses 1 cycle after accept with cause 0/1 and exc_addr=req_addr, and the FSM stays in IDLE.
REQ-025 Without LSU_MISALIGN_TRAP_EN, misaligned accesses SHALL proceed with the offending low address bits forced to 0 (half: addr[0]; word: addr[1:0]), and exc cause 0/1 SHALL never occur.

Verification
REQ-026 LB addr=0x103, rdata=0x80FF_FF00 with gnt and rvalid immediate -> done at N+3, wb_data=0xFFFF_FF80, wb_rd=latched rd.
REQ-027 SH addr=0x202, wdata=0x1234_ABCD -> mem_addr=0x200, mem_wdata=0xABCD_ABCD, mem_wstrb=1100, wb_we=0 on done.
REQ-028 Grant withheld for 5 cycles -> mem_req and mem_addr stable for all 5 cycles, req_ready=0 throughout; done follows rvalid by 1 cycle.
REQ-029 TIMEOUT_CYC=4, rvalid never returned -> exc=1, cause=2 exactly once, done=0, req_ready=1 on the next cycle.
REQ-030 LW addr=0x6: with the macro -> exc cause 0, exc_addr=0x6, mem_req never 1; without the macro -> mem_addr=0x4, normal completion.
REQ-031 rst_n pulsed low while in WAIT, late rvalid afterwards -> outputs at reset values, no done, next access completes normally.
